clk_rst_sequencer: RTL and testbench
====================================

// Module: clk_rst_sequencer
// PURPOSE
// - Synthesisable, multi-channel clock/reset generator for the ADC digital core.
// - From one master clock and one async reset, produces NUM_CH divided clocks, per-channel tick pulses and staggered per-channel resets.
// - Sits at the top of the ADC digital core and drives the SAR sample/convert domains.
// - Supports runtime divider reload and an optional countermeasure: dithered clock edges.
// PARAMETERS
// NUM_CH       4   number of output channels (1..8)
// DIV_W        8   width of each channel divider value
// SYNC_STAGES  2   reset-deassertion synchroniser depth (>=2)
// HOLD_CYCLES  16  cycles all channels stay in reset after sync release (>=1)
// STAGGER      4   cycles between successive channel reset releases (>=1)
// PORTS
// clk       in   1           master clock, rising edge
// rst       in   1           asynchronous reset, active-high
// en        in   1           run enable; low freezes all dividers in RUN
// div       in   NUM_CH*DIV_W  per-channel divide value; ch i = div[i*DIV_W +: DIV_W]
// div_load  in   1           1-cycle strobe: capture div into shadow registers
// ch_clk    out  NUM_CH      divided clocks, registered
// ch_tick   out  NUM_CH      1-cycle pulse on the cycle ch_clk[i] rises
// ch_rst    out  NUM_CH      per-channel reset, active-high, registered
// ready     out  1           all channels released and sequencer in RUN
// BEHAVIOUR
// - Reset values: ch_clk=0, ch_tick=0, ch_rst='1, ready=0, FSM=RESET, all counters=0, shadow/active div=0.
// - rst asserts all outputs to their reset values immediately (asynchronously), including mid-sequence or mid-RUN.
// - rst deassertion passes through a SYNC_STAGES flop chain; internal rst_s falls SYNC_STAGES rising edges after rst falls.
// - FSM states:
//   - RESET -> HOLD on the first cycle with rst_s=0.
//   - HOLD: count HOLD_CYCLES cycles; active div[i] tracks the div input every cycle.
//   - HOLD -> RELEASE: ch_rst[0] falls on the first RELEASE cycle.
//   - RELEASE: ch_rst[i] falls STAGGER*i cycles after ch_rst[0].
//   - RELEASE -> RUN one cycle after ch_rst[NUM_CH-1] falls; ready=1 from the first RUN cycle.
// - Divider, per channel i, while ch_rst[i]=0:
//   - Counter counts 0..div[i], wrapping to 0 at the terminal count, where ch_clk[i] toggles.
//   - Period = 2*(div[i]+1) clk cycles.
//   - First rise of ch_clk[i] occurs div[i]+1 cycles after ch_rst[i] falls.
//   - ch_tick[i]=1 exactly on the cycles where ch_clk[i] goes 0->1.
// - div[i]=0: channel stopped; ch_clk[i] held 0, no ticks. This is not divide-by-1.
// - Fastest output is div[i]=1 (period 4 cycles).
// - div_load:
//   - Captures all channels into the shadow registers.
//   - Each channel copies shadow->active at its next terminal count that lands on a ch_clk falling toggle (1->0), or immediately if the channel is stopped.
//   - Reload is therefore glitch-free; no half-period is ever truncated.
// - div_load in RESET/HOLD/RELEASE: ignored (HOLD tracking governs).
// - div_load coincident with a terminal count: the new value applies from the next period boundary, not the current one.
// - en=0 in RUN: counters, ch_clk and ch_rst hold; ch_tick forced 0; ready stays 1.
// - en is ignored outside RUN (the reset sequence always completes).
// - Width rule: counters are DIV_W bits; div=2**DIV_W-1 is legal and never overflows.
// CONFIGURATION
// - Macro CLK_RST_SEQUENCER_DITHER_EN defined:
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, steps once per RUN cycle while en=1.
//   - At each terminal-count check, channel i's effective terminal value is div[i]+lfsr[i].
//   - Each half-period randomly stretches by 0 or 1 cycle.
//   - ch_tick still marks each rise.
// - Macro undefined: no LFSR logic; exact period 2*(div[i]+1).
// TESTING
// - Reset sequence: NUM_CH=4, STAGGER=4, HOLD_CYCLES=16, rst high 5 cycles then low.
//   - rst_s falls after 2 edges.
//   - ch_rst[0] falls 16 cycles later; ch_rst[1..3] fall at +4/+8/+12.
//   - ready rises 1 cycle after ch_rst[3].
// - Division: div={8'd0,8'd3,8'd2,8'd1}.
//   - ch0 period 4, ch1 period 6, ch2 period 8.
//   - ch3 stays 0 with no ch_tick.
//   - Each ch_tick aligns with a rising ch_clk.
// - Reload: in RUN, div_load with ch0 1->5.
//   - Current ch0 period completes at 4 cycles; the next period is 12.
//   - No high/low phase shorter than 2 cycles.
// - Enable: en=0 for 7 cycles mid-high-phase.
//   - ch_clk frozen high, ch_tick=0 throughout.
//   - On en=1 the remaining phase resumes where it stopped.
// - Async reset mid-RUN: rst pulse between clock edges.
//   - ch_rst='1, ch_clk=0, ready=0 before the next edge.
//   - The full sequence then repeats with identical timing.
// - Dither (macro on): div=1.
//   - Every half-period is 2 or 3 cycles.
//   - Over 1000 periods both lengths occur.
//   - The sequence is repeatable from reset.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
// Clock/reset sequencer: reset synchroniser, staggered per-channel reset release and
// per-channel dividers with glitch-free reload. Define CLK_RST_SEQUENCER_DITHER_EN for LFSR edge dither.
module clk_rst_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic                    div_load,
  output logic [NUM_CH-1:0]       ch_clk,
  output logic [NUM_CH-1:0]       ch_tick,
  output logic [NUM_CH-1:0]       ch_rst,
  output logic                    ready
);

  localparam int REL_LAST = STAGGER * (NUM_CH - 1);
  localparam int SEQ_MAX  = (HOLD_CYCLES > REL_LAST + 1) ? HOLD_CYCLES : REL_LAST + 1;
  localparam int SEQ_W    = $clog2(SEQ_MAX + 1);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [SYNC_STAGES-1:0]       sync_q, sync_d;
  logic [SEQ_W-1:0]             seq_q, seq_d;
  logic [NUM_CH-1:0]            ch_clk_q, ch_clk_d, ch_tick_q, ch_tick_d;
  logic [NUM_CH-1:0]            ch_rst_q, ch_rst_d, pend_q, pend_d;
  logic                         ready_q, ready_d;
  logic [NUM_CH-1:0][DIV_W-1:0] act_q, act_d, shd_q, shd_d, cnt_q, cnt_d;
  logic                         run_en;
`ifdef CLK_RST_SEQUENCER_DITHER_EN
  logic [15:0]                  lfsr_q, lfsr_d;
  logic [NUM_CH-1:0]            ext_q, ext_d;
`endif

  // Next-state logic: reset sequencing, dividers and shadow reload
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b0};
    state_d   = state_q;
    seq_d     = seq_q;
    ch_rst_d  = ch_rst_q;
    ready_d   = ready_q;
    ch_clk_d  = ch_clk_q;
    ch_tick_d = '0;
    pend_d    = pend_q;
    act_d     = act_q;
    shd_d     = shd_q;
    cnt_d     = cnt_q;
    run_en    = (state_q == ST_RUN) ? en : 1'b1;
`ifdef CLK_RST_SEQUENCER_DITHER_EN
    ext_d     = ext_q;
    lfsr_d    = (state_q == ST_RUN && en) ?
                {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
`endif

    // Looking one stage ahead of rst_s makes HOLD start on the first cycle rst_s is low
    case (state_q)
      ST_RESET: begin
        if (!sync_q[SYNC_STAGES-2]) begin
          state_d = ST_HOLD;
          seq_d   = '0;
        end else begin
          state_d = ST_RESET;
        end
      end
      ST_HOLD: begin
        act_d = div;
        if (seq_q == SEQ_W'(HOLD_CYCLES - 1)) begin
          state_d     = ST_RELEASE;
          seq_d       = '0;
          ch_rst_d[0] = 1'b0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      ST_RELEASE: begin
        seq_d = seq_q + SEQ_W'(1);
        for (int i = 1; i < NUM_CH; i++) begin
          if (seq_d == SEQ_W'(STAGGER * i)) ch_rst_d[i] = 1'b0;
          else                              ch_rst_d[i] = ch_rst_q[i];
        end
        if (seq_q == SEQ_W'(REL_LAST)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RESET;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      if (!ch_rst_q[i] && run_en) begin
        if (act_q[i] == '0) begin
          cnt_d[i]    = '0;
          ch_clk_d[i] = 1'b0;
`ifdef CLK_RST_SEQUENCER_DITHER_EN
          ext_d[i]    = 1'b0;
`endif
          if (pend_q[i]) begin
            act_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
          end else begin
            act_d[i]  = act_q[i];
          end
        end else if (cnt_q[i] != act_q[i]) begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
`ifdef CLK_RST_SEQUENCER_DITHER_EN
        end else if (lfsr_q[i] && !ext_q[i]) begin
          ext_d[i] = 1'b1;
`endif
        end else begin
          cnt_d[i]     = '0;
          ch_clk_d[i]  = ~ch_clk_q[i];
          ch_tick_d[i] = ~ch_clk_q[i];
`ifdef CLK_RST_SEQUENCER_DITHER_EN
          ext_d[i]     = 1'b0;
`endif
          // New divide value only takes effect at a falling toggle, so no phase is cut short
          if (ch_clk_q[i] && pend_q[i]) begin
            act_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
          end else begin
            act_d[i]  = act_q[i];
          end
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end

    if (state_q == ST_RUN && div_load) begin
      shd_d  = div;
      pend_d = '1;
    end else begin
      shd_d  = shd_q;
    end
  end

  // State registers with asynchronous reset to the sequencer's idle values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= ST_RESET;
      seq_q     <= '0;
      ch_clk_q  <= '0;
      ch_tick_q <= '0;
      ch_rst_q  <= '1;
      ready_q   <= 1'b0;
      pend_q    <= '0;
      act_q     <= '0;
      shd_q     <= '0;
      cnt_q     <= '0;
`ifdef CLK_RST_SEQUENCER_DITHER_EN
      lfsr_q    <= 16'hACE1;
      ext_q     <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      seq_q     <= seq_d;
      ch_clk_q  <= ch_clk_d;
      ch_tick_q <= ch_tick_d;
      ch_rst_q  <= ch_rst_d;
      ready_q   <= ready_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      cnt_q     <= cnt_d;
`ifdef CLK_RST_SEQUENCER_DITHER_EN
      lfsr_q    <= lfsr_d;
      ext_q     <= ext_d;
`endif
    end
  end

  assign ch_clk  = ch_clk_q;
  assign ch_tick = ch_tick_q;
  assign ch_rst  = ch_rst_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench for clk_rst_sequencer: reset timing, division table, enable freeze,
// reload, async reset and randomized traffic against a half-period reference model.
module tb_clk_rst_sequencer;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int S      = 2;
  localparam int H      = 16;
  localparam int ST     = 4;
  localparam int REL0   = S + H;
  localparam int RUN_E  = REL0 + ST * (NUM_CH - 1) + 1;

  logic        clk = 1'b0;
  logic        rst, en, div_load;
  logic [31:0] div;
  logic [3:0]  ch_clk, ch_tick, ch_rst;
  logic        ready;

  clk_rst_sequencer #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .SYNC_STAGES(S),
                      .HOLD_CYCLES(H), .STAGGER(ST)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .div_load(div_load),
    .ch_clk(ch_clk), .ch_tick(ch_tick), .ch_rst(ch_rst), .ready(ready));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      div;
    logic [3:0][15:0] first_rise;
    logic [3:0][15:0] period;
  } vec_t;

  vec_t vecs [4];
  int   checks = 0, errors = 0;
  int   e;
  int   m_act [NUM_CH], m_shd [NUM_CH], m_phase [NUM_CH];
  logic [3:0] m_pend, m_clk, m_tick, prev_clk;
  int   rise_n [NUM_CH], first_rise [NUM_CH], second_rise [NUM_CH];
  int   seq_e [8];
  logic [3:0] seq_r [8];
  logic seq_rd [8];
  int   n, r0, f1, r1, f2;
  logic found, prev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, e);
    end
  endtask

  function automatic logic [3:0] exp_rst(input int ee);
    logic [3:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = (ee < REL0 + ST * i);
    return r;
  endfunction

  task automatic model_reset();
    e = 0; m_clk = '0; m_tick = '0; m_pend = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i] = 0; m_shd[i] = 0; m_phase[i] = 0;
    end
  endtask

  // Reference: each channel counts down the cycles left in its current half-period
  task automatic model_edge();
    int ep; logic in_run; logic [3:0] rpre;
    if (rst) begin
      model_reset();
      return;
    end
    ep = e; in_run = (ep >= RUN_E); rpre = exp_rst(ep);
    m_tick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rpre[i] && (!in_run || en)) begin
        if (m_act[i] == 0) begin
          m_clk[i] = 1'b0;
          if (m_pend[i]) begin m_act[i] = m_shd[i]; m_pend[i] = 1'b0; end
          m_phase[i] = m_act[i] + 1;
        end else begin
          m_phase[i] = m_phase[i] - 1;
          if (m_phase[i] == 0) begin
            if (m_clk[i] && m_pend[i]) begin m_act[i] = m_shd[i]; m_pend[i] = 1'b0; end
            m_clk[i]   = ~m_clk[i];
            m_tick[i]  = m_clk[i];
            m_phase[i] = m_act[i] + 1;
          end
        end
      end
    end
    if (ep + 1 > S && ep + 1 <= REL0)
      for (int i = 0; i < NUM_CH; i++) m_act[i] = int'(div[i*8 +: 8]);
    if (in_run && div_load)
      for (int i = 0; i < NUM_CH; i++) begin m_shd[i] = int'(div[i*8 +: 8]); m_pend[i] = 1'b1; end
    e = ep + 1;
    for (int i = 0; i < NUM_CH; i++)
      if (e == REL0 + ST * i) m_phase[i] = m_act[i] + 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ch_rst", 32'(ch_rst), 32'(exp_rst(e)));
    check("ready", 32'(ready), 32'(e >= RUN_E));
`ifndef CLK_RST_SEQUENCER_DITHER_EN
    check("ch_clk", 32'(ch_clk), 32'(m_clk));
    check("ch_tick", 32'(ch_tick), 32'(m_tick));
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_clk[i] && !prev_clk[i]) begin
        if (rise_n[i] == 0) first_rise[i] = e;
        else if (rise_n[i] == 1) second_rise[i] = e;
        rise_n[i]++;
      end
    end
    prev_clk = ch_clk;
  endtask

  // Called just after a sample point; pulses rst between clock edges
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("async ch_rst", 32'(ch_rst), 32'h0000_000F);
    check("async ch_clk", 32'(ch_clk), 32'h0);
    check("async ch_tick", 32'(ch_tick), 32'h0);
    check("async ready", 32'(ready), 32'h0);
    model_reset();
    prev_clk = '0;
    for (int i = 0; i < NUM_CH; i++) begin rise_n[i] = 0; first_rise[i] = 0; second_rise[i] = 0; end
    #1 rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{div: 32'h0003_0201, first_rise: {16'd0, 16'd30, 16'd25, 16'd20},
                period: {16'd0, 16'd8, 16'd6, 16'd4}};
    vecs[1] = '{div: 32'hFF00_0704, first_rise: {16'd286, 16'd0, 16'd30, 16'd23},
                period: {16'd512, 16'd0, 16'd16, 16'd10}};
    vecs[2] = '{div: 32'h0101_0101, first_rise: {16'd32, 16'd28, 16'd24, 16'd20},
                period: {16'd4, 16'd4, 16'd4, 16'd4}};
    vecs[3] = '{div: 32'h0201_0005, first_rise: {16'd33, 16'd28, 16'd0, 16'd24},
                period: {16'd6, 16'd4, 16'd0, 16'd12}};
    seq_e  = '{17, 18, 21, 22, 26, 29, 30, 31};
    seq_r  = '{4'hF, 4'hE, 4'hE, 4'hC, 4'h8, 4'h8, 4'h0, 4'h0};
    seq_rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b1; div_load = 1'b0; div = 32'h0003_0201;
    prev_clk = '0;
    for (int i = 0; i < NUM_CH; i++) begin rise_n[i] = 0; first_rise[i] = 0; second_rise[i] = 0; end
    model_reset();
    #1;
    check("reset ch_rst", 32'(ch_rst), 32'h0000_000F);
    check("reset ch_clk", 32'(ch_clk), 32'h0);
    check("reset ch_tick", 32'(ch_tick), 32'h0);
    check("reset ready", 32'(ready), 32'h0);
    repeat (5) step();
    rst = 1'b0;

    // Reset release timeline
    for (int k = 0; k < RUN_E + 2; k++) begin
      step();
      for (int j = 0; j < 8; j++) begin
        if (e == seq_e[j]) begin
          check("seq ch_rst", 32'(ch_rst), 32'(seq_r[j]));
          check("seq ready", 32'(ready), 32'(seq_rd[j]));
        end
      end
    end

`ifdef CLK_RST_SEQUENCER_DITHER_EN
    begin
      int dh [2][64];
      int n2, n3, last, idx;
      n2 = 0; n3 = 0;
      for (int run = 0; run < 2; run++) begin
        div = 32'h0101_0101;
        async_reset();
        repeat (RUN_E + 2) step();
        last = -1; idx = 0; prev = ch_clk[0];
        for (int k = 0; k < 6000; k++) begin
          step();
          if (ch_clk[0] != prev) begin
            if (last >= 0) begin
              check("dither half-period", 32'((e - last == 2) || (e - last == 3)), 32'h1);
              if (e - last == 2) n2++;
              if (e - last == 3) n3++;
              if (idx < 64) begin dh[run][idx] = e - last; idx++; end
            end
            last = e;
          end
          prev = ch_clk[0];
        end
      end
      check("dither saw 2", 32'(n2 > 0), 32'h1);
      check("dither saw 3", 32'(n3 > 0), 32'h1);
      for (int j = 0; j < 64; j++) check("dither repeat", 32'(dh[1][j]), 32'(dh[0][j]));
    end
`else
    // Division table, each entry entered through an async reset from RUN
    for (int v = 0; v < 4; v++) begin
      div = vecs[v].div;
      async_reset();
      repeat (900) step();
      for (int i = 0; i < NUM_CH; i++) begin
        if (vecs[v].period[i] == 16'd0) begin
          check("stopped rises", 32'(rise_n[i]), 32'h0);
        end else begin
          check("first rise", 32'(first_rise[i]), 32'(vecs[v].first_rise[i]));
          check("period", 32'(second_rise[i] - first_rise[i]), 32'(vecs[v].period[i]));
        end
      end
    end

    div = 32'h0003_0201;
    async_reset();
    repeat (RUN_E + 4) step();

    // Enable freeze in the middle of a ch1 high phase
    n = rise_n[1]; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin step(); found = (rise_n[1] != n); end
    check("en wait rise", 32'(found), 32'h1);
    step();
    en = 1'b0;
    repeat (7) begin
      step();
      check("en frozen clk", 32'(ch_clk[1]), 32'h1);
      check("en tick low", 32'(ch_tick), 32'h0);
    end
    en = 1'b1;
    step();
    check("en resume high", 32'(ch_clk[1]), 32'h1);
    step();
    check("en resume fall", 32'(ch_clk[1]), 32'h0);

    // Reload ch0 from 1 to 5 during a high phase
    n = rise_n[0]; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin step(); found = (rise_n[0] != n); end
    check("reload wait rise", 32'(found), 32'h1);
    r0 = e;
    div = 32'h0003_0205; div_load = 1'b1;
    step();
    div_load = 1'b0;
    f1 = -1; r1 = -1; f2 = -1; prev = ch_clk[0];
    for (int k = 0; k < 30; k++) begin
      step();
      if (prev && !ch_clk[0]) begin
        if (f1 < 0) f1 = e;
        else if (f2 < 0) f2 = e;
      end
      if (!prev && ch_clk[0] && r1 < 0) r1 = e;
      prev = ch_clk[0];
    end
    check("reload old high", 32'(f1 - r0), 32'd2);
    check("reload new low", 32'(r1 - r0), 32'd8);
    check("reload new period", 32'(f2 - f1), 32'd12);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      step();
      en = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 9) == 0);
      if (div_load || $urandom_range(0, 4) == 0)
        for (int i = 0; i < NUM_CH; i++) div[i*8 +: 8] = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 599) == 0) async_reset();
    end
    en = 1'b1; div_load = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
